// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: arbiter state
// encoding, byte width and the default source-header base value.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] HDR_BASE_DEF = 8'hA0;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: rotates the request vector so the slot
// after ptr sits at bit 0, priority-encodes, and rotates the result back.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] sel,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [NREQ-1:0] rot;
  int              start;
  int              off;
  int              pos;

  always_comb begin
    start = (int'(ptr) + 1) % NREQ;
    rot   = '0;
    for (int k = 0; k < NREQ; k++) begin
      rot[k] = req[(start + k) % NREQ];
    end
    // Scanning downwards leaves the lowest set rotated position in off.
    off = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = k;
      end
    end
    pos = (start + off) % NREQ;
    any = |req;
    idx = IDW'(pos);
    sel = any ? (NREQ'(1) << pos) : '0;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter sharing the uart write port among NREQ
// byte-stream requesters, optionally tagging each packet with a source header.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int                NREQ     = 4,
  parameter int                IDW      = 2,
  parameter bit                HDR_EN   = 1'b1,
  parameter logic [BYTE_W-1:0] HDR_BASE = HDR_BASE_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_last,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   tx_full,
  output logic                   wr_uart,
  output logic [BYTE_W-1:0]      w_data,
  output logic [NREQ-1:0]        grant,
  output logic                   busy
);

  state_t          state;
  logic [IDW-1:0]  gid;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] pick_sel;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            acc;

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .sel(pick_sel),
    .idx(pick_idx),
    .any(pick_any)
  );

  assign acc  = (state == DATA) && req_valid[gid] && !tx_full;
  assign busy = (state != IDLE);

  // Only the granted lane ever sees ready, and only while its bytes flow.
  always_comb begin
    wr_uart   = 1'b0;
    w_data    = '0;
    req_ready = '0;
    case (state)
      HDR: begin
        wr_uart = !tx_full;
        w_data  = HDR_BASE | BYTE_W'(gid);
      end
      DATA: begin
        wr_uart        = acc;
        w_data         = req_data[BYTE_W*gid +: BYTE_W];
        req_ready[gid] = acc;
      end
      default: ;
    endcase
  end

  // ptr remembers the last finisher so it gets lowest priority next round.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      gid   <= '0;
      ptr   <= IDW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick_sel;
            gid   <= pick_idx;
            state <= HDR_EN ? HDR : DATA;
          end
        end
        HDR: begin
          if (!tx_full) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (acc && req_last[gid]) begin
            state <= IDLE;
            ptr   <= gid;
            grant <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb against a packet-level reference model,
// plus directed priority, back-pressure, gap, reset and no-header scenarios.
module tb_uart_tx_arb;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic          tx_full, wr_uart, busy;
  logic [7:0]    w_data;

  logic [N-1:0]  nh_valid, nh_last, nh_ready, nh_grant;
  logic [8*N-1:0] nh_data;
  logic          nh_full, nh_wr, nh_busy;
  logic [7:0]    nh_wdata;

  int checks = 0;
  int errors = 0;

  int         rem [N];
  logic [7:0] cur [N];
  logic [N-1:0] mask, gap_mask;
  int p_valid, p_full, p_new, max_len;

  int owner;
  bit in_hdr;
  int last_served;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         done_q[$];

  always #5 clk = ~clk;

  uart_tx_arb #(.NREQ(N), .IDW(2), .HDR_EN(1'b1), .HDR_BASE(8'hA0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data), .grant(grant), .busy(busy)
  );

  uart_tx_arb #(.NREQ(N), .IDW(2), .HDR_EN(1'b0), .HDR_BASE(8'hA0)) dut_nh (
    .clk(clk), .reset(reset), .req_valid(nh_valid), .req_last(nh_last),
    .req_data(nh_data), .req_ready(nh_ready), .tx_full(nh_full),
    .wr_uart(nh_wr), .w_data(nh_wdata), .grant(nh_grant), .busy(nh_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      if (rem[i] == 0 && mask[i] && $urandom_range(99) < p_new) begin
        rem[i] = int'($urandom_range(max_len, 1));
        cur[i] = 8'($urandom);
      end
      req_valid[i]     = (rem[i] > 0) && ($urandom_range(99) < p_valid) && !gap_mask[i];
      req_last[i]      = (rem[i] == 1);
      req_data[8*i+:8] = cur[i];
    end
    tx_full = ($urandom_range(99) < p_full);
  endtask

  task automatic reset_model();
    owner       = -1;
    in_hdr      = 1'b0;
    last_served = N - 1;
  endtask

  task automatic check_cycle();
    logic [N-1:0] eg, er;
    logic [7:0]   ed;
    logic         ew;
    eg = '0; er = '0; ed = '0; ew = 1'b0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      if (in_hdr) begin
        ew = !tx_full;
        ed = 8'hA0 | 8'(owner);
      end else begin
        ew = req_valid[owner] && !tx_full;
        ed = req_data[8*owner+:8];
        er[owner] = ew;
      end
    end
    checkOutput("grant", grant, eg);
    checkOutput("busy", busy, owner >= 0);
    checkOutput("wr_uart", wr_uart, ew);
    checkOutput("w_data", w_data, ed);
    checkOutput("req_ready", req_ready, er);
    if (wr_uart) got_q.push_back(w_data);
    for (int i = 0; i < N; i++)
      if (wr_uart && req_ready[i] && req_last[i]) done_q.push_back(i);
  endtask

  task automatic update_model();
    bit found;
    found = 1'b0;
    if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (last_served + k) % N;
        if (!found && req_valid[idx]) begin
          found  = 1'b1;
          owner  = idx;
          in_hdr = 1'b1;
        end
      end
    end else if (in_hdr) begin
      if (!tx_full) begin
        exp_q.push_back(8'hA0 | 8'(owner));
        in_hdr = 1'b0;
      end
    end else if (req_valid[owner] && !tx_full) begin
      exp_q.push_back(cur[owner]);
      rem[owner]--;
      cur[owner] = 8'($urandom);
      if (rem[owner] == 0) begin
        last_served = owner;
        owner = -1;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      update_model();
      #1;
    end
  endtask

  task automatic compare_streams();
    int n;
    checkOutput("stream_len", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput("stream_byte", got_q[i], exp_q[i]);
      if (got_q[i] !== exp_q[i]) break;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_order(input string tag, input int a, input int b, input int c, input int cnt);
    checkOutput({tag, "_cnt"}, done_q.size() >= cnt, 1);
    if (done_q.size() >= 1) checkOutput({tag, "_0"}, done_q[0], a);
    if (done_q.size() >= 2) checkOutput({tag, "_1"}, done_q[1], b);
    if (cnt >= 3 && done_q.size() >= 3) checkOutput({tag, "_2"}, done_q[2], c);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin rem[i] = 0; cur[i] = 8'h00; end
    mask = '0; gap_mask = '0;
    p_valid = 100; p_full = 0; p_new = 100; max_len = 1;
    reset_model();
    req_valid = '0; req_last = '0; req_data = '0; tx_full = 1'b0;
    nh_valid = '0; nh_last = '0; nh_data = '0; nh_full = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_wr", wr_uart, 0);
    checkOutput("rst_wdata", w_data, 0);
    checkOutput("rst_ready", req_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] reset priority, single-byte packets from all lanes");
    mask = 4'b1111;
    run_cycles(40);
    check_order("prio", 0, 1, 2, 3);
    if (done_q.size() >= 4) checkOutput("prio_3", done_q[3], 3);
    compare_streams();
    mask = '0;
    run_cycles(30);
    checkOutput("drain_busy", busy, 0);

    $display("[TB] back-pressure in mid-packet");
    got_q.delete(); exp_q.delete(); done_q.delete();
    rem[2] = 3; cur[2] = 8'($urandom);
    run_cycles(3);
    p_full = 100;
    run_cycles(10);
    p_full = 0;
    run_cycles(10);
    checkOutput("bp_count", got_q.size(), 4);
    if (got_q.size() >= 1) checkOutput("bp_hdr", got_q[0], 8'hA2);
    compare_streams();

    $display("[TB] valid gap holds the grant");
    done_q.delete();
    rem[1] = 4; cur[1] = 8'($urandom);
    run_cycles(2);
    rem[3] = 2; cur[3] = 8'($urandom);
    run_cycles(2);
    gap_mask = 4'b0010;
    run_cycles(5);
    checkOutput("gap_grant", grant, 4'b0010);
    gap_mask = '0;
    run_cycles(20);
    check_order("gap", 1, 3, 0, 2);
    compare_streams();

    $display("[TB] reset mid-packet then fairness");
    mask = 4'b1111; p_valid = 80; p_full = 10; max_len = 4;
    for (int c = 0; c < 200; c++) begin
      run_cycles(1);
      if (owner >= 0 && !in_hdr) break;
    end
    checkOutput("reach_data", (owner >= 0 && !in_hdr), 1);
    compare_streams();
    reset = 1'b1;
    #1;
    checkOutput("mrst_grant", grant, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_wr", wr_uart, 0);
    checkOutput("mrst_ready", req_ready, 0);
    checkOutput("mrst_wdata", w_data, 0);
    reset_model();
    for (int i = 0; i < N; i++) rem[i] = 0;
    rem[0] = 3; rem[2] = 2; cur[0] = 8'($urandom); cur[2] = 8'($urandom);
    mask = 4'b0001; p_valid = 100; p_full = 0; max_len = 2;
    @(posedge clk); #1;
    reset = 1'b0;
    done_q.delete();
    run_cycles(40);
    check_order("fair", 0, 2, 0, 3);
    compare_streams();
    mask = '0;
    run_cycles(30);

    $display("[TB] randomized traffic");
    done_q.delete();
    mask = 4'b1111; p_valid = 70; p_full = 25; p_new = 30; max_len = 5;
    run_cycles(3000);
    checkOutput("rand_pkts", done_q.size() > 10, 1);
    compare_streams();

    $display("[TB] no-header latency");
    nh_valid = 4'b0100; nh_last = 4'b0100; nh_data = 32'h005C_0000; nh_full = 1'b0;
    @(negedge clk);
    checkOutput("nh_pre_wr", nh_wr, 0);
    checkOutput("nh_pre_grant", nh_grant, 0);
    @(posedge clk); #1;
    checkOutput("nh_grant", nh_grant, 4'b0100);
    checkOutput("nh_busy", nh_busy, 1);
    checkOutput("nh_wr", nh_wr, 1);
    checkOutput("nh_wdata", nh_wdata, 8'h5C);
    checkOutput("nh_ready", nh_ready, 4'b0100);
    @(posedge clk); #1;
    checkOutput("nh_end_busy", nh_busy, 0);
    checkOutput("nh_end_grant", nh_grant, 0);
    checkOutput("nh_end_wr", nh_wr, 0);
    nh_valid = '0; nh_last = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
